bcd_score_counter: RTL and testbench
====================================

BCD_SCORE_COUNTER -- requirements
Module: bcd_score_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits in the score, legal range 1..8.
REQ-002 Parameter STEP_M3, default 5: step size used when mode=3, legal range 1..9.
REQ-003 Port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port state, input, 1 bit: game-active enable; key events are scored only while it is 1.
REQ-006 Port key, input, 2 bits: answer code; 1 = correct (T), 0 = wrong (F), 2 or 3 = no key.
REQ-007 Port mode, input, 2 bits: step select; 0 gives step 1, 1 gives step 2, 2 gives step 3, 3 gives step STEP_M3.
REQ-008 Port clr, input, 1 bit: synchronous clear of the score.
REQ-009 Port score, output, 4*DIGITS bits: BCD score; the most-significant digit is in the top nibble.
REQ-010 Port sat_max, output, 1 bit: high while every score digit is 9.
REQ-011 Port sat_zero, output, 1 bit: high while every score digit is 0.
REQ-012 Port upd, output, 1 bit: one-cycle pulse, high in the cycle after the score changed.
REQ-013 Port best, output, 4*DIGITS bits: highest score reached (see Configuration).

Function
REQ-014 The block SHALL register key into key_prev every cycle, independent of state.
REQ-015 A valid event SHALL be key in {0,1} with key_prev in {2,3} (press edge only); holding a key SHALL score once.
REQ-016 A change of key directly between 0 and 1, with no release in between, SHALL NOT be an event.
REQ-017 On a valid event with state=1 and key=1, the score SHALL become score + step, in decimal, with carry rippled across all DIGITS.
REQ-018 On a valid event with state=1 and key=0, the score SHALL become score - step, in decimal, with borrow rippled across all DIGITS.
REQ-019 An add SHALL saturate at all-9s (e.g. 9998 + 3 gives 9999).
REQ-020 A subtract SHALL floor at zero (e.g. 0001 - 2 gives 0000).
REQ-021 Step SHALL be sampled from mode in the same cycle as the event.
REQ-022 Latency SHALL be one clock: an event detected in cycle n (combinational on key and key_prev) is visible on score after edge n+1.
REQ-023 clr=1 SHALL load score with 0 at the next edge and has priority over any event in the same cycle.
REQ-024 With state=0, score SHALL hold; clr SHALL still act.
REQ-025 upd SHALL be registered and high for exactly one cycle after the edge where the score value changed.
REQ-026 upd SHALL stay low for saturated no-change events.
REQ-027 upd SHALL go high for a clr that changes a nonzero score.
REQ-028 sat_max and sat_zero SHALL be combinational decodes of the registered score.
REQ-029 No digit of score SHALL ever hold a value above 9.

Reset
REQ-030 rst_n=0 SHALL immediately set score=0, best=0, upd=0, and key_prev=2 (no key), regardless of clk.
REQ-031 After reset, sat_zero=1 and sat_max=0.
REQ-032 A key already held (0 or 1) when rst_n releases SHALL NOT score until it is released and pressed again.

Configuration
REQ-033 Macro SCORE_BEST_EN defined: best SHALL register max(best, next score) at every edge.
REQ-034 With SCORE_BEST_EN defined, best SHALL be unaffected by clr and cleared only by rst_n.
REQ-035 Macro SCORE_BEST_EN undefined: no best register is built and the best port SHALL be constant 0.

Verification (DIGITS=4, STEP_M3=5)
REQ-036 Reset, then state=1, mode=0, key 2->1->2 three times -> score 0003, upd pulses three times, sat_zero=0.
REQ-037 Score 0999, mode=1, key=1 press -> score 1001 after one clock; score 9997, mode=3, key=1 press -> 9999, sat_max=1.
REQ-038 Score 1000, mode=2, key=0 press -> 0997; score 0001, mode=1, key=0 press -> 0000, sat_zero=1; then key=0 press again -> 0000, upd stays 0.
REQ-039 Key held at 1 for 10 cycles -> exactly one increment; key 1->0 with no release -> no change; state=0 with a press -> no change.
REQ-040 clr=1 with a key=1 event in the same cycle -> score 0000; rst_n pulled low mid-cycle -> score 0000 immediately, without waiting for clk.
REQ-041 SCORE_BEST_EN defined: score raised to 0042, then clr, then raised to 0010 -> best stays 0042. SCORE_BEST_EN undefined: best stays 0000 throughout.

Source files
------------

// File: rtl/bcd_score_counter.sv
// BCD score counter: press-edge scoring, saturating add/subtract, sync clear.
// Define SCORE_BEST_EN to build the high-score (best) register.
module bcd_score_counter #(
    parameter int DIGITS  = 4,
    parameter int STEP_M3 = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                state,
    input  logic [1:0]          key,
    input  logic [1:0]          mode,
    input  logic                clr,
    output logic [4*DIGITS-1:0] score,
    output logic                sat_max,
    output logic                sat_zero,
    output logic                upd,
    output logic [4*DIGITS-1:0] best
);
    localparam int W = 4*DIGITS;

    logic [1:0]   r_key_prev;
    logic         r_armed;
    logic [W-1:0] r_score;
    logic         r_upd;

    logic         w_event;
    logic [3:0]   w_step;
    logic [W-1:0] w_all9;
    logic [W-1:0] w_sum;
    logic [W-1:0] w_diff;
    logic         w_carry;
    logic         w_borrow;
    logic [W-1:0] w_next;

    // r_armed blocks a key that was already held when reset released
    assign w_event = r_armed & ~key[1] & r_key_prev[1];

    always_comb begin
        w_step = 4'd1;
        unique case (mode)
            2'd0: w_step = 4'd1;
            2'd1: w_step = 4'd2;
            2'd2: w_step = 4'd3;
            2'd3: w_step = 4'(STEP_M3);
        endcase
    end

    always_comb begin
        w_all9 = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_all9[4*i +: 4] = 4'd9;
        end
    end

    always_comb begin
        logic [4:0] v_t;
        logic [3:0] v_c;
        v_t   = '0;
        v_c   = w_step;
        w_sum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v_t = {1'b0, r_score[4*i +: 4]} + {1'b0, v_c};
            if (v_t > 5'd9) begin
                w_sum[4*i +: 4] = 4'(v_t - 5'd10);
                v_c = 4'd1;
            end else begin
                w_sum[4*i +: 4] = v_t[3:0];
                v_c = 4'd0;
            end
        end
        w_carry = (v_c != 4'd0);
    end

    always_comb begin
        logic [3:0] v_d;
        logic [3:0] v_b;
        v_d    = '0;
        v_b    = w_step;
        w_diff = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v_d = r_score[4*i +: 4];
            if (v_d < v_b) begin
                w_diff[4*i +: 4] = 4'({1'b0, v_d} + 5'd10 - {1'b0, v_b});
                v_b = 4'd1;
            end else begin
                w_diff[4*i +: 4] = v_d - v_b;
                v_b = 4'd0;
            end
        end
        w_borrow = (v_b != 4'd0);
    end

    always_comb begin
        w_next = r_score;
        if (clr) begin
            w_next = '0;
        end else if (w_event && state) begin
            if (key[0]) begin
                w_next = w_carry ? w_all9 : w_sum;
            end else begin
                w_next = w_borrow ? '0 : w_diff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_prev <= 2'd2;
            r_armed    <= 1'b0;
            r_score    <= '0;
            r_upd      <= 1'b0;
        end else begin
            r_key_prev <= key;
            r_armed    <= r_armed | key[1];
            r_score    <= w_next;
            r_upd      <= (w_next != r_score);
        end
    end

    assign score    = r_score;
    assign upd      = r_upd;
    assign sat_max  = (r_score == w_all9);
    assign sat_zero = (r_score == '0);

`ifdef SCORE_BEST_EN
    logic [W-1:0] r_best;

    // BCD order matches binary order, so a plain compare finds the max
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best <= '0;
        end else if (w_next > r_best) begin
            r_best <= w_next;
        end
    end

    assign best = r_best;
`else
    assign best = '0;
`endif

endmodule

// File: tb/tb_bcd_score_counter.sv
// Bench for bcd_score_counter: integer score model plus directed presses.
// Honours SCORE_BEST_EN when defined for the whole build.
module tb_bcd_score_counter;
    localparam int DIGITS  = 4;
    localparam int STEP_M3 = 5;
    localparam int MAXV    = 9999;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        state = 1'b0;
    logic [1:0]  key   = 2'd2;
    logic [1:0]  mode  = 2'd0;
    logic        clr   = 1'b0;
    logic [15:0] score;
    logic [15:0] best;
    logic        sat_max;
    logic        sat_zero;
    logic        upd;

    int n_pass  = 0;
    int n_total = 0;
    int upd_cnt = 0;
    bit run     = 1'b0;

    int         m_score;
    int         m_best;
    bit         m_upd;
    logic [1:0] m_kp;
    bit         m_armed;

    always #5 clk = ~clk;

    bcd_score_counter #(
        .DIGITS (DIGITS),
        .STEP_M3(STEP_M3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .state   (state),
        .key     (key),
        .mode    (mode),
        .clr     (clr),
        .score   (score),
        .sat_max (sat_max),
        .sat_zero(sat_zero),
        .upd     (upd),
        .best    (best)
    );

    function automatic int bcd2int(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (v[4*i +: 4] > 4'd9) return -1;
            r = r * 10 + int'(v[4*i +: 4]);
        end
        return r;
    endfunction

    function automatic int step_of(input logic [1:0] m);
        case (m)
            2'd0: return 1;
            2'd1: return 2;
            2'd2: return 3;
            default: return STEP_M3;
        endcase
    endfunction

    function automatic int exp_best();
`ifdef SCORE_BEST_EN
        return m_best;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Score model: decimal integer arithmetic clamped to [0, MAXV]
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_score <= 0;
            m_best  <= 0;
            m_upd   <= 1'b0;
            m_kp    <= 2'd2;
            m_armed <= 1'b0;
        end else begin : mdl
            int nxt;
            int st;
            st  = step_of(mode);
            nxt = m_score;
            if (clr) begin
                nxt = 0;
            end else if (state && key < 2 && m_kp >= 2 && m_armed) begin
                if (key == 2'd1) nxt = (m_score + st > MAXV) ? MAXV : m_score + st;
                else nxt = (m_score - st < 0) ? 0 : m_score - st;
            end
            m_upd   <= (nxt != m_score);
            m_score <= nxt;
            if (nxt > m_best) m_best <= nxt;
            m_kp    <= key;
            if (key >= 2) m_armed <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("score", bcd2int(score), m_score);
            check("upd", int'(upd), int'(m_upd));
            check("sat_max", int'(sat_max), int'(m_score == MAXV));
            check("sat_zero", int'(sat_zero), int'(m_score == 0));
            check("best", bcd2int(best), exp_best());
            if (upd) upd_cnt++;
        end
    end

    task automatic press(input logic [1:0] k, input logic [1:0] m);
        @(posedge clk); #2;
        key  = k;
        mode = m;
        @(posedge clk); #2;
        key  = 2'd2;
    endtask

    task automatic do_clr();
        @(posedge clk); #2;
        clr = 1'b1;
        @(posedge clk); #2;
        clr = 1'b0;
    endtask

    task automatic climb(input int target);
        int d;
        while (m_score < target) begin
            d = target - m_score;
            press(2'd1, d >= 5 ? 2'd3 : d >= 3 ? 2'd2 : d >= 2 ? 2'd1 : 2'd0);
        end
    endtask

    task automatic descend(input int target);
        int d;
        while (m_score > target) begin
            d = m_score - target;
            press(2'd0, d >= 5 ? 2'd3 : d >= 3 ? 2'd2 : d >= 2 ? 2'd1 : 2'd0);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_score", bcd2int(score), 0);
        check("rst_sat_zero", int'(sat_zero), 1);
        check("rst_sat_max", int'(sat_max), 0);
        check("rst_upd", int'(upd), 0);
        check("rst_best", bcd2int(best), 0);
        run = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // three single-step presses
        state = 1'b1;
        upd_cnt = 0;
        repeat (3) press(2'd1, 2'd0);
        @(posedge clk); #2;
        check("inc3_score", bcd2int(score), 3);
        check("inc3_sat_zero", int'(sat_zero), 0);
        check("inc3_upd_pulses", upd_cnt, 3);

        // carry ripple and saturation at the top
        climb(999);
        press(2'd1, 2'd1);
        check("carry_1001", bcd2int(score), 1001);
        check("carry_upd", int'(upd), 1);
        climb(9997);
        press(2'd1, 2'd3);
        check("sat_9999", bcd2int(score), 9999);
        check("sat_max_hi", int'(sat_max), 1);
        press(2'd1, 2'd0);
        check("sat_hold", bcd2int(score), 9999);
        check("sat_no_upd", int'(upd), 0);

        // clear from nonzero, borrow ripple and floor at zero
        do_clr();
        check("clr_score", bcd2int(score), 0);
        check("clr_upd", int'(upd), 1);
        climb(1000);
        press(2'd0, 2'd2);
        check("borrow_0997", bcd2int(score), 997);
        descend(1);
        press(2'd0, 2'd1);
        check("floor_0000", bcd2int(score), 0);
        check("floor_sat_zero", int'(sat_zero), 1);
        press(2'd0, 2'd1);
        check("floor_hold", bcd2int(score), 0);
        check("floor_no_upd", int'(upd), 0);

        // held key, direct 1->0 change, inactive game
        climb(10);
        @(posedge clk); #2;
        key = 2'd1; mode = 2'd0;
        repeat (10) @(posedge clk);
        #2 key = 2'd2;
        @(posedge clk); #2;
        check("held_once", bcd2int(score), 11);
        @(posedge clk); #2 key = 2'd1;
        @(posedge clk); #2 key = 2'd0;
        @(posedge clk); #2 key = 2'd2;
        @(posedge clk); #2;
        check("no_release", bcd2int(score), 12);
        state = 1'b0;
        press(2'd1, 2'd0);
        do_clr();
        check("state0_hold_clr", bcd2int(score), 0);
        state = 1'b1;

        // clear beats a same-cycle event; async reset mid-cycle
        climb(7);
        @(posedge clk); #2;
        key = 2'd1; clr = 1'b1;
        @(posedge clk); #2;
        key = 2'd2; clr = 1'b0;
        check("clr_priority", bcd2int(score), 0);
        climb(25);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_score", bcd2int(score), 0);
        check("async_rst_upd", int'(upd), 0);
        key = 2'd1;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("held_thru_rst", bcd2int(score), 0);
        key = 2'd2;
        press(2'd1, 2'd0);
        check("press_after_rst", bcd2int(score), 1);

        // high score survives a clear
        reset_pulse();
        @(posedge clk); #2;
        climb(42);
        do_clr();
        climb(10);
        @(posedge clk); #2;
        check("best_score", bcd2int(score), 10);
`ifdef SCORE_BEST_EN
        check("best_kept", bcd2int(best), 42);
`else
        check("best_zero", bcd2int(best), 0);
`endif

        @(posedge clk); #2;
        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
